// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions used by decode, the register file and the multiply/divide unit.
package rv32m_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Radix-2 unsigned shift-add multiplier / restoring divider; one bit per step, XLEN steps after start.
// No backpressure of its own: steps only while the controller holds step_i.
module mdu_iter_core
    import rv32m_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                step_i,
    input  logic                div_mode_i,
    input  logic [XLEN-1:0]     op_a_i,
    input  logic [XLEN-1:0]     op_b_i,
    output logic                done_o,
    output logic [2*XLEN-1:0]   acc_o
);

    localparam int CNT_W = $clog2(XLEN);

    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_d;
    logic [XLEN-1:0]   opb_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     sub_diff;

    // Multiply: multiplier sits in the low half and shifts out LSB-first while the
    // product builds in the high half. Divide: {remainder, quotient} shifts left,
    // quotient bits enter at the bottom; the MSB of sub_diff is the borrow.
    always_comb begin
        add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        sub_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
        if (div_mode_i) begin
            if (sub_diff[XLEN]) begin
                acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            end else begin
                acc_d = {sub_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_d = {add_sum, acc_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            opb_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            acc_q <= {{XLEN{1'b0}}, op_a_i};
            opb_q <= op_b_i;
            cnt_q <= '0;
        end else if (step_i) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign done_o = (cnt_q == CNT_W'(XLEN - 1));
    assign acc_o  = acc_q;

endmodule

// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit: 33 cycles accept-to-valid for iterated ops, next cycle for divide special cases.
// Accepts only when idle; the result is held in DONE until out_ready_i, and flush_i kills any op.
module mul_div_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [2:0]            op_i,
    input  logic [XLEN-1:0]       rs1_data_i,
    input  logic [XLEN-1:0]       rs2_data_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [XLEN-1:0]       result_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o
);
    import rv32m_pkg::*;

    mdu_state_e state_q, state_d;

    md_op_e                op_in;
    md_op_e                op_q;
    logic                  neg_q;
    logic [REG_ADDR_W-1:0] rd_q;

    logic                  a_neg, b_neg, neg_d;
    logic [XLEN-1:0]       a_mag, b_mag;
    logic                  is_div, is_rem, div_zero, div_ovf, special;
    logic [XLEN-1:0]       special_res;

    logic                  start, step, load_special, load_fix;
    logic                  core_done;
    logic [2*XLEN-1:0]     acc;
    logic [2*XLEN-1:0]     prod;
    logic [XLEN-1:0]       div_val;
    logic [XLEN-1:0]       fix_res;

    // Operand decode happens on the raw inputs so everything is latched on the accept edge.
    always_comb begin
        op_in    = md_op_e'(op_i);
        a_neg    = rs1_data_i[XLEN-1] & (op_in inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
        b_neg    = rs2_data_i[XLEN-1] & (op_in inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
        a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
        b_mag    = b_neg ? -rs2_data_i : rs2_data_i;
        is_div   = op_i[2];
        is_rem   = op_i[2] & op_i[1];
        // Remainder follows the dividend; product and quotient follow the sign difference.
        neg_d    = is_rem ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div & (rs2_data_i == '0);
        div_ovf  = is_div & ~op_i[0] & (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_data_i == '1);
        special  = div_zero | div_ovf;
        if (div_zero) begin
            special_res = is_rem ? rs1_data_i : '1;
        end else begin
            special_res = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    always_comb begin
        prod = neg_q ? -acc : acc;
        div_val = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (!op_q[2]) begin
            fix_res = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
            fix_res = neg_q ? -div_val : div_val;
        end
    end

    always_comb begin
        state_d      = state_q;
        start        = 1'b0;
        step         = 1'b0;
        load_special = 1'b0;
        load_fix     = 1'b0;
        if (flush_i) begin
            state_d = MDU_IDLE;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (in_valid_i) begin
                        if (special) begin
                            load_special = 1'b1;
                            state_d      = MDU_DONE;
                        end else begin
                            start   = 1'b1;
                            state_d = MDU_CALC;
                        end
                    end
                end
                MDU_CALC: begin
                    step = 1'b1;
                    if (core_done) begin
                        state_d = MDU_FIX;
                    end
                end
                MDU_FIX: begin
                    load_fix = 1'b1;
                    state_d  = MDU_DONE;
                end
                MDU_DONE: begin
                    if (out_ready_i) begin
                        state_d = MDU_IDLE;
                    end
                end
                default: state_d = MDU_IDLE;
            endcase
        end
    end

    assign in_ready_o = (state_q == MDU_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MDU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q        <= MD_MUL;
            neg_q       <= 1'b0;
            rd_q        <= '0;
            out_valid_o <= 1'b0;
            result_o    <= '0;
            rd_addr_o   <= '0;
        end else begin
            out_valid_o <= (state_d == MDU_DONE);
            if (start || load_special) begin
                op_q  <= op_in;
                neg_q <= neg_d;
                rd_q  <= rd_addr_i;
            end
            if (load_special) begin
                result_o  <= special_res;
                rd_addr_o <= rd_addr_i;
            end else if (load_fix) begin
                result_o  <= fix_res;
                rd_addr_o <= rd_q;
            end
        end
    end

    mdu_iter_core u_core (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start),
        .step_i     (step),
        .div_mode_i (op_q[2]),
        .op_a_i     (a_mag),
        .op_b_i     (b_mag),
        .done_o     (core_done),
        .acc_o      (acc)
    );

endmodule
